rv32_mem: RTL

- Memory stage of the rv32 pipeline; consumes the registered control/data bundle produced by the execute stage.
- Resolves branches and drives the data bus with a ready handshake.
- Aligns load data and forms store byte masks; raises stall while a bus access is outstanding.
- Registers the result bundle toward writeback.

---
 rtl/rv32_mem_pkg.sv | 39 +++
 rtl/rv32_mem_align.sv | 54 +++++
 rtl/rv32_mem.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rv32_mem_pkg.sv
// ============================================================================
// Module      : rv32_mem_pkg
// Description : Shared encodings for the rv32 memory stage: access widths,
//               branch ops, FSM states and the branch resolution helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_mem_pkg;

  localparam logic [1:0] RV32_MEM_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] RV32_MEM_WIDTH_HALF = 2'd1;
  localparam logic [1:0] RV32_MEM_WIDTH_WORD = 2'd2;

  localparam logic [1:0] RV32_BRANCH_OP_NEVER    = 2'd0;
  localparam logic [1:0] RV32_BRANCH_OP_ZERO     = 2'd1;
  localparam logic [1:0] RV32_BRANCH_OP_NON_ZERO = 2'd2;
  localparam logic [1:0] RV32_BRANCH_OP_ALWAYS   = 2'd3;

  typedef enum logic [0:0] {
    RV32_MEM_STATE_IDLE = 1'b0,
    RV32_MEM_STATE_WAIT = 1'b1
  } rv32_mem_state_e;

  function automatic logic rv32_branch_taken(input logic [1:0] op, input logic non_zero);
    logic taken;
    taken = 1'b0;
    case (op)
      RV32_BRANCH_OP_ZERO:     taken = !non_zero;
      RV32_BRANCH_OP_NON_ZERO: taken = non_zero;
      RV32_BRANCH_OP_ALWAYS:   taken = 1'b1;
      default:                 taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32_mem_align.sv
// ============================================================================
// Module      : rv32_mem_align
// Description : Load extract/extend, store lane replication, byte-enable mask
//               and misalignment detection for one data-bus access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_mem_align
  import rv32_mem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_width,
  input  logic        i_zero_extend,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_data,
  output logic [31:0] o_load_value,
  output logic [31:0] o_store_value,
  output logic [3:0]  o_byte_mask,
  output logic        o_misaligned
);

  logic [31:0] w_shifted;

  assign w_shifted = i_load_data >> {i_addr_lo, 3'b000};

  // Widths other than byte/half behave as a full word.
  always_comb begin
    o_load_value  = w_shifted;
    o_store_value = i_store_data;
    o_byte_mask   = 4'b1111;
    o_misaligned  = |i_addr_lo;
    case (i_width)
      RV32_MEM_WIDTH_BYTE: begin
        o_load_value  = i_zero_extend ? {24'h0, w_shifted[7:0]}
                                      : {{24{w_shifted[7]}}, w_shifted[7:0]};
        o_store_value = {4{i_store_data[7:0]}};
        o_byte_mask   = 4'b0001 << i_addr_lo;
        o_misaligned  = 1'b0;
      end
      RV32_MEM_WIDTH_HALF: begin
        o_load_value  = i_zero_extend ? {16'h0, w_shifted[15:0]}
                                      : {{16{w_shifted[15]}}, w_shifted[15:0]};
        o_store_value = {2{i_store_data[15:0]}};
        o_byte_mask   = 4'b0011 << i_addr_lo;
        o_misaligned  = i_addr_lo[0];
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rv32_mem.sv
// ============================================================================
// Module      : rv32_mem
// Description : rv32 memory stage - branch resolution, data-bus handshake with
//               optional timeout, load/store alignment and writeback registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_mem
  import rv32_mem_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        valid_in,
  input  logic        branch_predicted_taken_in,
  input  logic        alu_non_zero_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_zero_extend_in,
  input  logic        mem_fence_in,
  input  logic        rd_write_in,
  input  logic [1:0]  mem_width_in,
  input  logic [1:0]  branch_op_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  input  logic [31:0] branch_pc_in,
  output logic [31:0] data_address_out,
  output logic        data_read_out,
  output logic        data_write_out,
  output logic [3:0]  data_write_mask_out,
  output logic [31:0] data_write_value_out,
  input  logic [31:0] data_read_value_in,
  input  logic        data_ready_in,
  output logic        stall_out,
  output logic        branch_taken_out,
  output logic        branch_mispredicted_out,
  output logic [31:0] branch_pc_out,
  output logic        valid_out,
  output logic        rd_write_out,
  output logic        bus_error_out,
  output logic [4:0]  rd_out,
  output logic [31:0] rd_value_out
);

  localparam logic [31:0] c_TIMEOUT_LIMIT = BUS_TIMEOUT_CYCLES;
  localparam logic        c_TIMEOUT_EN    = (BUS_TIMEOUT_CYCLES != 0);

  rv32_mem_state_e r_state, w_next_state;
  logic [31:0] r_wait_cnt;
  logic        r_flushed;
  logic [31:0] r_addr, r_store_data;
  logic [1:0]  r_width;
  logic        r_zext, r_read, r_write, r_rd_write;
  logic [4:0]  r_rd;
  logic        r_valid, r_rd_write_o, r_bus_error;
  logic [4:0]  r_rd_o;
  logic [31:0] r_rd_value;

  logic        w_in_wait, w_mem_op, w_raw_misaligned, w_misaligned, w_access;
  logic        w_idle_req, w_req, w_timeout, w_stall, w_retire, w_err, w_taken;
  logic [31:0] w_sel_addr, w_sel_store, w_load_value, w_store_value, w_cap_value;
  logic [1:0]  w_sel_width;
  logic        w_sel_zext, w_sel_read, w_sel_write;
  logic [3:0]  w_mask;

  assign w_in_wait = (r_state == RV32_MEM_STATE_WAIT);

  // While waiting, the bus is driven from the bundle captured at issue so it
  // stays stable even if the upstream registers change (e.g. on a flush).
  assign w_sel_addr  = w_in_wait ? r_addr       : result_in;
  assign w_sel_store = w_in_wait ? r_store_data : rs2_value_in;
  assign w_sel_width = w_in_wait ? r_width      : mem_width_in;
  assign w_sel_zext  = w_in_wait ? r_zext       : mem_zero_extend_in;
  assign w_sel_read  = w_in_wait ? r_read       : mem_read_in;
  assign w_sel_write = w_in_wait ? r_write      : mem_write_in;

  rv32_mem_align u_align (
    .i_addr_lo     (w_sel_addr[1:0]),
    .i_width       (w_sel_width),
    .i_zero_extend (w_sel_zext),
    .i_store_data  (w_sel_store),
    .i_load_data   (data_read_value_in),
    .o_load_value  (w_load_value),
    .o_store_value (w_store_value),
    .o_byte_mask   (w_mask),
    .o_misaligned  (w_raw_misaligned)
  );

  // Fences have no store buffer to drain, so they never touch the bus.
  assign w_mem_op     = (mem_read_in | mem_write_in) & !mem_fence_in;
  assign w_misaligned = !w_in_wait & valid_in & w_mem_op & w_raw_misaligned;
  assign w_access     = !w_in_wait & valid_in & w_mem_op & !w_raw_misaligned;
  assign w_idle_req   = w_access & !flush_in & !reset;
  assign w_timeout    = c_TIMEOUT_EN & w_in_wait & !data_ready_in &
                        (r_wait_cnt == (c_TIMEOUT_LIMIT - 32'd1));
  assign w_req        = w_idle_req | w_in_wait;
  assign w_stall      = (w_idle_req & !data_ready_in) |
                        (w_in_wait & !data_ready_in & !w_timeout);

  assign data_address_out     = {w_sel_addr[31:2], 2'b00};
  assign data_read_out        = w_req & w_sel_read;
  assign data_write_out       = w_req & w_sel_write;
  assign data_write_mask_out  = (w_req & w_sel_write) ? w_mask : 4'b0000;
  assign data_write_value_out = w_store_value;
  assign stall_out            = w_stall;

  assign w_taken                 = rv32_branch_taken(branch_op_in, alu_non_zero_in);
  assign branch_taken_out        = valid_in & !flush_in & w_taken;
  assign branch_mispredicted_out = valid_in & !flush_in & (w_taken != branch_predicted_taken_in);
  assign branch_pc_out           = branch_pc_in;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RV32_MEM_STATE_IDLE: if (w_idle_req && !data_ready_in) w_next_state = RV32_MEM_STATE_WAIT;
      RV32_MEM_STATE_WAIT: if (data_ready_in || w_timeout)  w_next_state = RV32_MEM_STATE_IDLE;
      default:             w_next_state = RV32_MEM_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RV32_MEM_STATE_IDLE;
      r_wait_cnt <= 32'd0;
      r_flushed  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_in_wait ? r_wait_cnt + 32'd1 : 32'd0;
      r_flushed  <= w_in_wait & (r_flushed | flush_in);
    end
  end

  always_ff @(posedge clk) begin
    if (!w_in_wait) begin
      r_addr       <= result_in;
      r_store_data <= rs2_value_in;
      r_width      <= mem_width_in;
      r_zext       <= mem_zero_extend_in;
      r_read       <= mem_read_in;
      r_write      <= mem_write_in;
      r_rd         <= rd_in;
      r_rd_write   <= rd_write_in;
    end
  end

  // A flush seen at any point of a wait turns the eventual completion into a bubble.
  assign w_retire    = w_in_wait ? ((data_ready_in | w_timeout) & !r_flushed & !flush_in)
                                 : (valid_in & !flush_in & !w_stall);
  assign w_err       = w_in_wait ? w_timeout : w_misaligned;
  assign w_cap_value = w_sel_read ? w_load_value : w_sel_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_rd_write_o <= 1'b0;
      r_bus_error  <= 1'b0;
      r_rd_o       <= 5'd0;
      r_rd_value   <= 32'd0;
    end else if (!stall_in) begin
      if (w_retire) begin
        r_valid      <= 1'b1;
        r_rd_write_o <= (w_in_wait ? r_rd_write : rd_write_in) & !w_err;
        r_bus_error  <= w_err;
        r_rd_o       <= w_in_wait ? r_rd : rd_in;
        r_rd_value   <= w_cap_value;
      end else begin
        r_valid      <= 1'b0;
        r_rd_write_o <= 1'b0;
        r_bus_error  <= 1'b0;
      end
    end
  end

  assign valid_out     = r_valid;
  assign rd_write_out  = r_rd_write_o;
  assign bus_error_out = r_bus_error;
  assign rd_out        = r_rd_o;
  assign rd_value_out  = r_rd_value;

endmodule

`default_nettype wire
